// File: rtl/mux_select_arbiter_rr4.sv
// Round-robin arbiter driving the select/enable inputs of a 4:1 tristate mux.
// Grants one of four requesters at a time, preempts an owner after MAX_HOLD
// cycles when others wait, and floats the mux (enable=0) when nobody owns it.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous, active-high
//   request - per-requester bus request, held until done
//   select  - registered index of the current (or last) owner
//   enable  - registered, high while an owner holds the bus
//   grant   - registered one-hot grant, 1 << select when enable, else 0
module mux_select_arbiter_rr4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] request,
    output logic [1:0] select,
    output logic       enable,
    output logic [3:0] grant
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t        state, state_n;
    logic [1:0]    last, last_n;
    logic [CW-1:0] count, count_n;
    logic [1:0]    select_n;
    logic          enable_n;
    logic [3:0]    grant_n;

    logic [3:0]    owner_mask;
    logic [3:0]    others;
    logic [1:0]    win;

    // First set request bit searching base+1, base+2, base+3, base (mod 4).
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            last   <= 2'd3;
            count  <= '0;
            select <= 2'd0;
            enable <= 1'b0;
            grant  <= 4'b0000;
        end else begin
            state  <= state_n;
            last   <= last_n;
            count  <= count_n;
            select <= select_n;
            enable <= enable_n;
            grant  <= grant_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        last_n     = last;
        count_n    = count;
        select_n   = select;
        enable_n   = enable;
        grant_n    = grant;
        owner_mask = 4'b0001 << select;
        others     = request & ~owner_mask;
        win        = 2'd0;

        unique case (state)
            IDLE: begin
                if (|request) begin
                    win      = rr_pick(last, request);
                    state_n  = OWNED;
                    last_n   = win;
                    count_n  = '0;
                    select_n = win;
                    enable_n = 1'b1;
                    grant_n  = 4'b0001 << win;
                end
            end
            OWNED: begin
                if (|(request & owner_mask)) begin
                    // Owner still wants the bus: preempt only at the tenure limit.
                    if (count == HOLD_LAST && |others) begin
                        win      = rr_pick(select, others);
                        last_n   = win;
                        count_n  = '0;
                        select_n = win;
                        grant_n  = 4'b0001 << win;
                    end else if (count != HOLD_LAST) begin
                        count_n = count + CW'(1);
                    end
                end else if (|request) begin
                    // Release with others pending: hand over with no idle bubble.
                    win      = rr_pick(select, request);
                    last_n   = win;
                    count_n  = '0;
                    select_n = win;
                    grant_n  = 4'b0001 << win;
                end else begin
                    // Release with nobody pending: float the mux, keep select.
                    state_n  = IDLE;
                    count_n  = '0;
                    enable_n = 1'b0;
                    grant_n  = 4'b0000;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_select_arbiter_rr4.sv
// Self-checking bench for mux_select_arbiter_rr4: directed scenarios with
// literal expectations plus randomized requests against a behavioural model.
module tb_mux_select_arbiter_rr4;

    localparam int MAX_HOLD = 8;

    logic       clock;
    logic       reset;
    logic [3:0] request;
    logic [1:0] select;
    logic       enable;
    logic [3:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owner index, bus-owned flag, rr pointer, cycles held.
    int m_sel  = 0;
    int m_last = 3;
    int m_held = 0;
    bit m_en   = 0;
    bit m_valid = 0;

    mux_select_arbiter_rr4 #(.MAX_HOLD(MAX_HOLD), .CW(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .request(request),
        .select (select),
        .enable (enable),
        .grant  (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int rr_next(input int base, input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(base + k) % 4]) return (base + k) % 4;
        end
        return base;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Model: owner holds the bus; after MAX_HOLD held cycles it yields to waiters.
    always @(posedge clock) begin
        logic [3:0] others;
        int w;
        if (reset) begin
            m_en = 0; m_sel = 0; m_last = 3; m_held = 0; m_valid = 1;
        end else if (m_valid) begin
            if (!m_en) begin
                if (request != 4'b0) begin
                    w = rr_next(m_last, request);
                    m_en = 1; m_sel = w; m_last = w; m_held = 1;
                end
            end else if (request[m_sel]) begin
                others = request;
                others[m_sel] = 1'b0;
                if (m_held >= MAX_HOLD && others != 4'b0) begin
                    w = rr_next(m_sel, others);
                    m_sel = w; m_last = w; m_held = 1;
                end else if (m_held < 1000) begin
                    m_held++;
                end
            end else if (request != 4'b0) begin
                w = rr_next(m_sel, request);
                m_sel = w; m_last = w; m_held = 1;
            end else begin
                m_en = 0;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("model_enable", int'(enable), int'(m_en));
            check("model_select", int'(select), m_sel);
            check("model_grant", int'(grant), m_en ? (1 << m_sel) : 0);
        end
    end

    initial begin
        reset   = 1'b1;
        request = 4'b0000;
        step(2);
        check("reset_enable", int'(enable), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_select", int'(select), 0);

        // First grant after reset goes to requester 0.
        reset = 1'b0; request = 4'b1111;
        step(1);
        check("first_select", int'(select), 0);
        check("first_grant", int'(grant), 4'b0001);
        check("first_enable", int'(enable), 1);
        request = 4'b0000;
        step(1);
        check("first_release_enable", int'(enable), 0);

        // Rotation between 1 and 3 at the tenure limit.
        request = 4'b1010;
        step(1);
        check("rot_owner1", int'(select), 1);
        step(MAX_HOLD - 1);
        check("rot_still1", int'(grant), 4'b0010);
        step(1);
        check("rot_owner3", int'(grant), 4'b1000);
        check("rot_enable", int'(enable), 1);
        step(MAX_HOLD);
        check("rot_back1", int'(select), 1);

        // Release handover from 0 to 2 without a bubble.
        request = 4'b0001;
        step(1);
        check("ho_owner0", int'(select), 0);
        request = 4'b0101;
        step(2);
        request = 4'b0100;
        step(1);
        check("ho_select", int'(select), 2);
        check("ho_grant", int'(grant), 4'b0100);
        check("ho_enable", int'(enable), 1);

        // Sole owner releases: mux floats, select holds.
        request = 4'b0000;
        step(1);
        check("idle_enable", int'(enable), 0);
        check("idle_grant", int'(grant), 0);
        check("idle_select", int'(select), 2);
        request = 4'b0001;
        step(1);
        check("idle_regrant", int'(select), 0);

        // No contention: owner 3 keeps the bus indefinitely.
        request = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("solo_grant", int'(grant), 4'b1000);
        end

        // Reset mid-tenure of owner 1.
        request = 4'b0010;
        step(1);
        check("mid_owner1", int'(select), 1);
        request = 4'b0011;
        reset = 1'b1;
        step(1);
        check("mid_reset_enable", int'(enable), 0);
        check("mid_reset_grant", int'(grant), 0);
        reset = 1'b0;
        step(1);
        check("mid_regrant", int'(grant), 4'b0001);

        // Randomized hold-until-done traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r;
            r = request;
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    if ($urandom_range(0, 9) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[i] = 1'b1;
                end
            end
            request = r;
            reset = ($urandom_range(0, 199) == 0);
            step(1);
            n_checks++;
            if (enable ? (grant != (4'b0001 << select)) : (grant != 4'b0000)) begin
                n_fail++;
                $display("FAIL onehot: grant %b select %0d enable %0b", grant, select, enable);
            end
        end
        reset = 1'b0;
        request = 4'b0000;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
